// File: rtl/hex_sr_pkg.sv
// Shared constants and word type for the hex shift-register tile.
package hex_sr_pkg;

  localparam int WIDTH_DEFAULT  = 6;
  localparam int LENGTH_DEFAULT = 40;

  typedef logic [WIDTH_DEFAULT-1:0] hex_word_t;

endpackage

// File: rtl/hex_sr_stage.sv
// One WIDTH-bit storage stage of the hex shift register, cleared asynchronously.
module hex_sr_stage #(
  parameter int WIDTH = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else begin
      q <= d;
    end
  end

endmodule

// File: rtl/hex_shift_register.sv
// LENGTH-deep, WIDTH-wide shift register; recirc feeds the oldest word back into stage 0.
module hex_shift_register
  import hex_sr_pkg::*;
#(
  parameter int LENGTH = LENGTH_DEFAULT,
  parameter int WIDTH  = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             recirc,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out
);

  if (LENGTH < 1 || WIDTH < 1) begin : g_param_err
    $error("hex_shift_register: LENGTH and WIDTH must both be at least 1");
  end

  logic [WIDTH-1:0] stage_q [LENGTH];

  for (genvar i = 0; i < LENGTH; i++) begin : g_stage
    logic [WIDTH-1:0] d;

    // Only stage 0 sees the recirculate mux; with LENGTH=1 it selects its own output, i.e. a hold.
    if (i == 0) begin : g_head
      assign d = recirc ? stage_q[LENGTH-1] : data_in;
    end else begin : g_body
      assign d = stage_q[i-1];
    end

    hex_sr_stage #(
      .WIDTH (WIDTH)
    ) u_stage (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (d),
      .q     (stage_q[i])
    );
  end

  assign data_out = stage_q[LENGTH-1];

endmodule

// File: tb/tb_hex_shift_register.sv
// Directed bench for hex_shift_register: 40-deep instance driven by a 6-bit counter, plus a LENGTH=1 instance.
module tb_hex_shift_register;
  import hex_sr_pkg::*;

  localparam int LEN = 40;

  logic      clk = 1'b0;
  logic      rst_n;
  logic      recirc;
  hex_word_t data_in;
  hex_word_t data_out;
  logic      recirc1;
  hex_word_t data_in1;
  hex_word_t data_out1;

  int        n_vec = 0;
  int        n_err = 0;
  int        p = 0;
  hex_word_t exp_q[$];
  hex_word_t exp_w;

  // ---------------- clock / reset ----------------
  always #10 clk = ~clk;

  hex_shift_register #(.LENGTH(LEN), .WIDTH(6)) u_dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .recirc   (recirc),
    .data_in  (data_in),
    .data_out (data_out)
  );

  hex_shift_register #(.LENGTH(1), .WIDTH(6)) u_dut1 (
    .clk      (clk),
    .rst_n    (rst_n),
    .recirc   (recirc1),
    .data_in  (data_in1),
    .data_out (data_out1)
  );

  // ---------------- driver tasks ----------------
  // Period p starts 1 ns after a rising edge; the counter word for the period is applied there.
  task automatic apply_period();
    data_in = hex_word_t'(p);
    exp_q.push_back(data_in);
    @(negedge clk);
  endtask

  task automatic end_period();
    @(posedge clk);
    #1;
    p++;
  endtask

  task automatic release_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    p = 0;
    exp_q.delete();
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset_initial();
    #5;
    n_vec++;
    if (data_out !== 6'h00) begin
      n_err++;
      $display("FAIL reset_initial: data_out=%h expected 00", data_out);
    end
    n_vec++;
    if (data_out1 !== 6'h00) begin
      n_err++;
      $display("FAIL reset_initial_len1: data_out1=%h expected 00", data_out1);
    end
  endtask

  task automatic test_fill_delay();
    recirc = 1'b0;
    release_reset();
    while (p <= 103) begin
      apply_period();
      exp_w = (p < LEN) ? 6'h00 : exp_q.pop_front();
      n_vec++;
      if (data_out !== exp_w) begin
        n_err++;
        $display("FAIL fill_delay: period %0d data_out=%h expected %h", p, data_out, exp_w);
      end
      if (p == 40 || p == 41 || p == 63) begin
        exp_w = (p == 40) ? 6'h00 : (p == 41) ? 6'h01 : 6'h17;
        n_vec++;
        if (data_out !== exp_w) begin
          n_err++;
          $display("FAIL fill_spot: period %0d data_out=%h expected %h", p, data_out, exp_w);
        end
      end
      end_period();
    end
  endtask

  task automatic test_counter_wrap();
    while (p <= 199) begin
      apply_period();
      exp_w = exp_q.pop_front();
      n_vec++;
      if (data_out !== exp_w) begin
        n_err++;
        $display("FAIL counter_wrap: period %0d data_out=%h expected %h", p, data_out, exp_w);
      end
      if (p == 104 || p == 167) begin
        exp_w = (p == 104) ? 6'h00 : 6'h3F;
        n_vec++;
        if (data_out !== exp_w) begin
          n_err++;
          $display("FAIL wrap_spot: period %0d data_out=%h expected %h", p, data_out, exp_w);
        end
      end
      end_period();
    end
  endtask

  // From period 200 the 40 words held (inputs of periods 160..199 = 0x20..0x3F,0x00..0x07) rotate.
  task automatic test_recirculate();
    recirc = 1'b1;
    while (p <= 319) begin
      apply_period();
      if (p < 240) exp_w = exp_q.pop_front();
      else         exp_w = hex_word_t'(160 + (p - 200) % LEN);
      n_vec++;
      if (data_out !== exp_w) begin
        n_err++;
        $display("FAIL recirculate: period %0d data_out=%h expected %h", p, data_out, exp_w);
      end
      if (p == 200 || p == 239 || p == 240 || p == 279 || p == 280) begin
        exp_w = (p == 239 || p == 279) ? 6'h07 : 6'h20;
        n_vec++;
        if (data_out !== exp_w) begin
          n_err++;
          $display("FAIL recirc_spot: period %0d data_out=%h expected %h", p, data_out, exp_w);
        end
      end
      end_period();
    end
    exp_q.delete();
  endtask

  task automatic test_recirc_reset();
    // Still rotating: period 320 shows 0x20, then reset lands mid-period with no clock edge.
    #4;
    rst_n = 1'b0;
    #1;
    n_vec++;
    if (data_out !== 6'h00) begin
      n_err++;
      $display("FAIL recirc_reset_async: data_out=%h expected 00", data_out);
    end
    end_period();
    release_reset();
    while (p < 100) begin
      data_in = hex_word_t'(p * 5 + 9);
      @(negedge clk);
      n_vec++;
      if (data_out !== 6'h00) begin
        n_err++;
        $display("FAIL recirc_reset_hold: period %0d data_out=%h expected 00", p, data_out);
      end
      end_period();
    end
  endtask

  task automatic test_reset_midrun();
    recirc = 1'b0;
    rst_n  = 1'b0;
    release_reset();
    while (p <= 45) begin
      apply_period();
      exp_w = (p < LEN) ? 6'h00 : exp_q.pop_front();
      n_vec++;
      if (data_out !== exp_w) begin
        n_err++;
        $display("FAIL reset_refill: period %0d data_out=%h expected %h", p, data_out, exp_w);
      end
      end_period();
    end
    n_vec++;
    if (data_out !== 6'h06) begin
      n_err++;
      $display("FAIL reset_pre: data_out=%h expected 06", data_out);
    end
    #4;
    rst_n = 1'b0;
    #1;
    n_vec++;
    if (data_out !== 6'h00) begin
      n_err++;
      $display("FAIL reset_async: data_out=%h expected 00", data_out);
    end
    for (int i = 0; i < 3; i++) begin
      data_in = hex_word_t'(6'h2A + i);
      @(negedge clk);
      n_vec++;
      if (data_out !== 6'h00) begin
        n_err++;
        $display("FAIL reset_hold: cycle %0d data_out=%h expected 00", i, data_out);
      end
      end_period();
    end
  endtask

  task automatic test_length_one();
    hex_word_t vals[5];
    vals = '{6'h15, 6'h2A, 6'h3F, 6'h00, 6'h01};
    recirc1 = 1'b0;
    release_reset();
    for (int i = 0; i < 5; i++) begin
      data_in1 = vals[i];
      @(negedge clk);
      if (i > 0) begin
        n_vec++;
        if (data_out1 !== vals[i-1]) begin
          n_err++;
          $display("FAIL len1_delay: step %0d data_out1=%h expected %h", i, data_out1, vals[i-1]);
        end
      end
      end_period();
    end
    recirc1 = 1'b1;
    for (int i = 0; i < 8; i++) begin
      data_in1 = hex_word_t'(i * 7 + 3);
      @(negedge clk);
      n_vec++;
      if (data_out1 !== 6'h01) begin
        n_err++;
        $display("FAIL len1_hold: step %0d data_out1=%h expected 01", i, data_out1);
      end
      end_period();
    end
  endtask

  // ---------------- sequence and final report ----------------
  initial begin
    rst_n    = 1'b0;
    recirc   = 1'b0;
    data_in  = '0;
    recirc1  = 1'b0;
    data_in1 = '0;
    test_reset_initial();
    test_fill_delay();
    test_counter_wrap();
    test_recirculate();
    test_recirc_reset();
    test_reset_midrun();
    test_length_one();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
